// File: rtl/vecmac_acc_stream.sv
// vecmac_acc_stream: LANES-wide int8 dot product per beat, accumulated over
// a vector (terminated by in_last), results drained through a FWFT FIFO.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        beat handshake; in_ready is credit based
//   in_a, in_b               LANES packed int8 operands, lane k = [8k+:8]
//   in_signed                lane mode, taken from the first beat of a vector
//   in_last                  final beat of a vector
//   out_valid/out_ready      result handshake at the FIFO head
//   out_data, out_ovf        accumulated result and sticky overflow flag
//
// Pipeline: stage 0 lane products, stage 1 half-sums, stage 2 beat sum,
// stage 3 accumulator, then FIFO push. vld_pipe/last_pipe track each stage.

module vecmac_lane (
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  input  logic               sgn,
  output logic signed [16:0] p
);
  logic signed [8:0]  ax, bx;
  logic signed [17:0] full;
  assign ax   = {sgn & a[7], a};
  assign bx   = {sgn & b[7], b};
  assign full = ax * bx;
  // Signed range [-16256,16384] and unsigned max 65025 both fit 17 bits.
  assign p    = full[16:0];
endmodule

module vecmac_acc_stream #(
  parameter int LANES     = 8,
  parameter int ACC_W     = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_a,
  input  logic [8*LANES-1:0]   in_b,
  input  logic                 in_signed,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_ovf
);
  localparam int SW     = 17 + $clog2(LANES);
  localparam int HALF   = LANES / 2;
  localparam int STAGES = 3;
  localparam int PW     = $clog2(OUT_DEPTH);
  localparam int CW     = PW + 1;

  // ---------------- input side: vector tracking ----------------
  logic accept, vec_mid, vec_mode, beat_mode;
  assign accept    = in_valid & in_ready;
  // Mode comes from in_signed only on the first beat of a vector.
  assign beat_mode = vec_mid ? vec_mode : in_signed;

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_mid  <= 1'b0;
      vec_mode <= 1'b0;
    end else if (accept) begin
      vec_mid <= !in_last;
      if (!vec_mid) vec_mode <= in_signed;
    end
  end

  // ---------------- control shift registers ----------------
  logic [STAGES:0]   vld_pipe, last_pipe;
  logic [STAGES-1:0] first_pipe, mode_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      last_pipe  <= '0;
      first_pipe <= '0;
      mode_pipe  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], accept};
      last_pipe  <= {last_pipe[STAGES-1:0], accept & in_last};
      first_pipe <= {first_pipe[STAGES-2:0], !vec_mid};
      mode_pipe  <= {mode_pipe[STAGES-2:0], beat_mode};
    end
  end

  // ---------------- stage 0: lane products ----------------
  logic [LANES-1:0][16:0] prod, prod_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vecmac_lane u_lane (
      .a   (in_a[8*k+:8]),
      .b   (in_b[8*k+:8]),
      .sgn (beat_mode),
      .p   (prod[k])
    );
  end

  always_ff @(posedge clk) prod_q <= prod;

  // ---------------- stage 1: two half-sums ----------------
  logic [SW-1:0] h_lo, h_hi, h_lo_q, h_hi_q;

  always_comb begin
    h_lo = '0;
    h_hi = '0;
    for (int k = 0; k < HALF; k++) begin
      h_lo = h_lo + SW'($signed(prod_q[k]));
      h_hi = h_hi + SW'($signed(prod_q[k+HALF]));
    end
  end

  always_ff @(posedge clk) begin
    h_lo_q <= h_lo;
    h_hi_q <= h_hi;
  end

  // ---------------- stage 2: beat sum ----------------
  logic [SW-1:0] beat_q;
  always_ff @(posedge clk) beat_q <= h_lo_q + h_hi_q;

  // ---------------- stage 3: accumulator ----------------
  logic [ACC_W-1:0] acc, ext;
  logic [ACC_W:0]   sum_x;
  logic             acc_ovf, step_ovf;

  // One extra bit exposes carry-out (unsigned) or sign disagreement (signed).
  always_comb begin
    ext = mode_pipe[2] ? ACC_W'($signed(beat_q)) : ACC_W'(beat_q);
    if (mode_pipe[2]) begin
      sum_x    = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
      step_ovf = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    end else begin
      sum_x    = {1'b0, acc} + {1'b0, ext};
      step_ovf = sum_x[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (vld_pipe[2]) begin
      if (first_pipe[2]) begin
        acc     <= ext;
        acc_ovf <= 1'b0;
      end else begin
        acc     <= sum_x[ACC_W-1:0];
        acc_ovf <= acc_ovf | step_ovf;
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [ACC_W-1:0] mem_data [OUT_DEPTH];
  logic             mem_ovf  [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [2:0]       inflight;
  logic             push, pop;

  assign push      = last_pipe[STAGES];
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_ovf   = out_valid & mem_ovf[rd_ptr];

  // Results already promised: every in_last still in flight reserves a slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STAGES; i++) inflight = inflight + 3'(last_pipe[i]);
  end
  assign in_ready = (int'(count) + int'(inflight)) < OUT_DEPTH;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= acc;
      mem_ovf[wr_ptr]  <= acc_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_vecmac_acc_stream.sv
module tb_vecmac_acc_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_a, in_b;
  logic        in_signed, in_last;
  logic        in_valid_m, in_ready_m, out_valid_m, out_ready_m, out_ovf_m;
  logic [31:0] out_data_m;
  logic        in_valid_n, in_ready_n, out_valid_n, out_ready_n, out_ovf_n;
  logic [19:0] out_data_n;
  logic        ready_man, rnd_en, rnd_bit;

  int checks = 0;
  int failures = 0;

  logic [32:0] q_m[$];
  logic [20:0] q_n[$];

  longint m_acc [2];
  bit     m_ovf [2];
  bit     m_mid [2];
  bit     m_mode[2];

  always #5 clk = ~clk;

  assign out_ready_m = rnd_en ? rnd_bit : ready_man;

  vecmac_acc_stream dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid_m), .out_ready(out_ready_m),
    .out_data(out_data_m), .out_ovf(out_ovf_m)
  );

  vecmac_acc_stream #(.ACC_W(20)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid_n), .out_ready(out_ready_n),
    .out_data(out_data_n), .out_ovf(out_ovf_n)
  );

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Scoreboard pop: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid_m && out_ready_m) begin
      checks++;
      if (q_m.size() == 0) begin
        failures++;
        $display("FAIL main_unexpected got %h expected none", {out_ovf_m, out_data_m});
      end else begin
        logic [32:0] e;
        e = q_m.pop_front();
        if ({out_ovf_m, out_data_m} !== e) begin
          failures++;
          $display("FAIL main_result got ovf=%0b data=%0d expected ovf=%0b data=%0d",
                   out_ovf_m, $signed(out_data_m), e[32], $signed(e[31:0]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_n && out_ready_n) begin
      checks++;
      if (q_n.size() == 0) begin
        failures++;
        $display("FAIL narrow_unexpected got %h expected none", {out_ovf_n, out_data_n});
      end else begin
        logic [20:0] e;
        e = q_n.pop_front();
        if ({out_ovf_n, out_data_n} !== e) begin
          failures++;
          $display("FAIL narrow_result got ovf=%0b data=%0d expected ovf=%0b data=%0d",
                   out_ovf_n, out_data_n, e[20], e[19:0]);
        end
      end
    end
  end

  function automatic longint dot(input logic [63:0] a, input logic [63:0] b, input bit s);
    longint r = 0;
    for (int k = 0; k < 8; k++) begin
      int ax, bx;
      ax = s ? int'($signed(a[8*k+:8])) : int'(a[8*k+:8]);
      bx = s ? int'($signed(b[8*k+:8])) : int'(b[8*k+:8]);
      r += longint'(ax * bx);
    end
    return r;
  endfunction

  task automatic model_beat(input bit sel, input logic [63:0] a, input logic [63:0] b,
                            input bit s, input bit last);
    bit     md;
    longint d, lo, hi, v;
    int     w;
    w  = sel ? 20 : 32;
    md = m_mid[sel] ? m_mode[sel] : s;
    d  = dot(a, b, md);
    if (!m_mid[sel]) begin
      m_mode[sel] = s;
      m_acc[sel]  = d;
      m_ovf[sel]  = 1'b0;
    end else begin
      m_acc[sel] = m_acc[sel] + d;
    end
    if (md) begin
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << w) - 1;
    end
    if (m_acc[sel] < lo || m_acc[sel] > hi) m_ovf[sel] = 1'b1;
    m_mid[sel] = !last;
    if (last) begin
      v = m_acc[sel];
      if (sel) q_n.push_back({m_ovf[sel], v[19:0]});
      else     q_m.push_back({m_ovf[sel], v[31:0]});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input bit sel, input logic [63:0] a, input logic [63:0] b,
                      input bit s, input bit last);
    int n = 0;
    in_a = a; in_b = b; in_signed = s; in_last = last;
    if (sel) in_valid_n = 1'b1; else in_valid_m = 1'b1;
    @(negedge clk);
    while (!(sel ? in_ready_n : in_ready_m)) begin
      n++;
      if (n > 2000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout got in_ready=0 expected 1 within 2000 cycles");
        in_valid_m = 1'b0; in_valid_n = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid_m = 1'b0; in_valid_n = 1'b0;
    model_beat(sel, a, b, s, last);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_m.size() != 0 || q_n.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q_m.size() != 0 || q_n.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d expected 0", name, q_m.size() + q_n.size());
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_ovf[i] = 0; m_mid[i] = 0; m_mode[i] = 0;
    end
    q_m.delete();
    q_n.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    checks += 4;
    if (out_valid_m !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b expected 0", out_valid_m); end
    if (out_data_m !== 32'd0) begin failures++; $display("FAIL rst_out_data got %h expected 0", out_data_m); end
    if (out_ovf_m !== 1'b0)   begin failures++; $display("FAIL rst_out_ovf got %b expected 0", out_ovf_m); end
    if (in_ready_m !== 1'b1)  begin failures++; $display("FAIL rst_in_ready got %b expected 1", in_ready_m); end
  endtask

  task automatic test_unsigned_latency();
    ready_man = 1'b1;
    send(0, {8{8'hFF}}, {8{8'hFF}}, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_m !== (i == 4)) begin
        failures++;
        $display("FAIL latency_edge%0d got out_valid=%b expected %b", i, out_valid_m, (i == 4));
      end
    end
    checks++;
    if (out_data_m !== 32'd520200) begin
      failures++;
      $display("FAIL unsigned_ff got %0d expected 520200", out_data_m);
    end
    drain("unsigned");
  endtask

  task automatic test_signed();
    send(0, {8{8'h80}}, {8{8'h80}}, 1'b1, 1'b1);
    send(0, {8{8'h80}}, {8{8'h7F}}, 1'b1, 1'b1);
    drain("signed");
  endtask

  task automatic test_multibeat();
    send(0, {8{8'h01}}, {8{8'h01}}, 1'b0, 1'b0);
    idle(3);
    send(0, {8{8'h01}}, {8{8'h01}}, 1'b1, 1'b0);
    idle(2);
    send(0, {8{8'h01}}, {8{8'h01}}, 1'b1, 1'b1);
    // Mode flip on a later beat where it would change the lane values.
    send(0, {8{8'hFF}}, {8{8'hFF}}, 1'b0, 1'b0);
    idle(1);
    send(0, {8{8'hFF}}, {8{8'hFF}}, 1'b1, 1'b1);
    drain("multibeat");
    checks++;
    if (out_valid_m !== 1'b0) begin failures++; $display("FAIL multibeat_empty got %b expected 0", out_valid_m); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a;
    ready_man = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = {8{8'(i + 1)}};
      send(0, a, {8{8'h01}}, 1'b0, 1'b1);
      checks++;
      if (in_ready_m !== (i < 3)) begin
        failures++;
        $display("FAIL bp_in_ready_after%0d got %b expected %b", i + 1, in_ready_m, (i < 3));
      end
    end
    idle(8);
    checks += 2;
    if (in_ready_m !== 1'b0)  begin failures++; $display("FAIL bp_full_in_ready got %b expected 0", in_ready_m); end
    if (out_valid_m !== 1'b1) begin failures++; $display("FAIL bp_full_out_valid got %b expected 1", out_valid_m); end
    ready_man = 1'b1;
    for (int i = 4; i < 6; i++) begin
      a = {8{8'(i + 1)}};
      send(0, a, {8{8'h01}}, 1'b0, 1'b1);
    end
    drain("backpressure");
  endtask

  task automatic test_random();
    rnd_en = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      logic [63:0] a, b;
      bit s, last;
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      s    = 1'($urandom_range(0, 1));
      last = ($urandom_range(0, 3) == 0) || (i == 4095);
      if ($urandom_range(0, 15) == 0) idle(1);
      send(0, a, b, s, last);
    end
    drain("random");
    rnd_en = 1'b0;
  endtask

  task automatic test_overflow();
    send(1, {8{8'hFF}}, {8{8'hFF}}, 1'b0, 1'b0);
    send(1, {8{8'hFF}}, {8{8'hFF}}, 1'b0, 1'b0);
    send(1, {8{8'hFF}}, {8{8'hFF}}, 1'b0, 1'b1);
    send(1, 64'd0, 64'd0, 1'b0, 1'b1);
    checks++;
    if (q_n.size() != 2 || q_n[0] !== {1'b1, 20'd512024} || q_n[1] !== {1'b0, 20'd0}) begin
      failures++;
      $display("FAIL ovf_model got queued=%0d expected 2 entries {1,512024},{0,0}", q_n.size());
    end
    drain("overflow");
  endtask

  task automatic test_reset_midvector();
    ready_man = 1'b0;
    send(0, {8{8'h02}}, {8{8'h01}}, 1'b0, 1'b1);
    send(0, {8{8'h05}}, {8{8'h05}}, 1'b1, 1'b0);
    send(0, {8{8'h05}}, {8{8'h05}}, 1'b1, 1'b0);
    idle(6);
    checks++;
    if (out_valid_m !== 1'b1) begin failures++; $display("FAIL rstmid_queued got %b expected 1", out_valid_m); end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    clear_model();
    checks += 3;
    if (out_valid_m !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got %b expected 0", out_valid_m); end
    if (in_ready_m !== 1'b1)  begin failures++; $display("FAIL rstmid_in_ready got %b expected 1", in_ready_m); end
    if (out_data_m !== 32'd0) begin failures++; $display("FAIL rstmid_out_data got %h expected 0", out_data_m); end
    ready_man = 1'b1;
    send(0, {8{8'h01}}, {8{8'h01}}, 1'b0, 1'b1);
    drain("rstmid");
  endtask

  initial begin
    rst = 1'b1;
    in_a = '0; in_b = '0; in_signed = 1'b0; in_last = 1'b0;
    in_valid_m = 1'b0; in_valid_n = 1'b0;
    out_ready_n = 1'b1;
    ready_man = 1'b1; rnd_en = 1'b0; rnd_bit = 1'b0;
    clear_model();
    test_reset();
    test_unsigned_latency();
    test_signed();
    test_multibeat();
    test_backpressure();
    test_overflow();
    test_random();
    test_reset_midvector();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vecmac_acc_stream.md
Name: vecmac_acc_stream

Overview:
- Parametrised successor to the fixed 8-lane int8 dot-product unit.
- Computes a LANES-wide int8 dot product per beat, in signed or unsigned mode.
- Accumulates beats into one result per vector; a vector ends on in_last, so vector length is unbounded.
- Results drain through an output FIFO with a valid/ready handshake. Input is credit-throttled so no result is ever dropped.
- Sits between the operand streamer and the result writeback in the int8 vecmac datapath.

Parameters:
- LANES, 8, number of int8 lanes per beat; power of two, 2..32.
- ACC_W, 32, accumulator/result width; must be >= 17+clog2(LANES).
- OUT_DEPTH, 4, output FIFO depth in results; power of two, >= 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- in_a  in  8*LANES  lane k = in_a[8k+:8].
- in_b  in  8*LANES  lane k = in_b[8k+:8].
- in_signed  in  1  1 = lanes are two's-complement int8; 0 = uint8.
- in_last  in  1  marks the final beat of a vector.
- out_valid  out  1  result at FIFO head.
- out_ready  in  1  consumer accepts the head when out_valid&&out_ready.
- out_data  out  ACC_W  accumulated dot product, two's complement in signed mode.
- out_ovf  out  1  sticky overflow for this result.

Behaviour:
- Reset:
  - Synchronous, active-high: rst sampled high at a clk edge clears the pipeline, accumulator, FIFO and in-flight counters.
  - After that edge: out_valid=0, out_data=0, out_ovf=0, in_ready=1.
  - Reset mid-vector discards all partial sums and queued results.
- Datapath, per accepted beat:
  - Product: p_k = a_k*b_k. In signed mode both operands are sign-extended; in unsigned mode both are zero-extended.
  - Each product is 17 bits with sign; beat sum width is 17+clog2(LANES).
  - The beat sum is extended to ACC_W per the vector mode before accumulation.
- Mode: latched from in_signed on the first beat of a vector. in_signed on later beats of the same vector is ignored.
- Pipeline:
  - 3 register stages for the dot product (partial-product, reduction, final add), then 1 accumulator stage.
  - Full throughput: one beat per cycle when in_ready=1.
- Latency: last beat accepted at edge t with the FIFO empty and out_ready don't-care -> out_valid=1 in the cycle after edge t+4.
- Accumulator:
  - First beat of a vector loads the beat sum; later beats add to it.
  - On in_last, the acc value plus the ovf flag are pushed into the FIFO and the accumulator restarts.
  - A single-beat vector (in_last on its first beat) is legal.
- Overflow:
  - out_ovf=1 if any intermediate or final sum leaves the ACC_W range: signed [-2^(ACC_W-1), 2^(ACC_W-1)-1], unsigned [0, 2^(ACC_W-1)... 2^ACC_W-1].
  - The flag is sticky within the vector and cleared at vector start.
  - out_data wraps modulo 2^ACC_W.
- Credit/backpressure:
  - inflight = number of in_last beats in pipeline stages not yet pushed.
  - in_ready = (fifo_count + inflight) < OUT_DEPTH, computed from registers only; no combinational path from in_valid or out_ready.
  - A beat with in_valid=1, in_ready=0 is not accepted; inputs are don't-care that cycle.
  - Non-last beats are also gated, for simplicity.
- FIFO:
  - First-word-fall-through: out_data/out_ovf are valid whenever out_valid=1 and are held stable while out_valid&&!out_ready.
  - Push and pop in the same cycle are allowed at any count, including full.
  - Pointers wrap modulo OUT_DEPTH.
  - Order is strictly preserved.
- Idle gaps: in_valid low between beats of a vector is allowed; the accumulator holds its value.

Test Plan:
- Unsigned, LANES=8: a=b=0xFF..FF, in_last=1, single beat -> out_data=520200, out_ovf=0; out_valid 4 edges after acceptance.
- Signed: a=b=0x80 per lane -> 131072. Next vector a=0x80.., b=0x7F.. -> out_data = -130048 (two's complement in ACC_W).
- Three beats of a=b=0x01..01 with idle cycles between, last on beat 3 -> single result 24. Mode flip on beat 2 ignored.
- Backpressure: out_ready=0, OUT_DEPTH+2 back-to-back single-beat vectors of distinct values:
  - in_ready drops once OUT_DEPTH results are committed;
  - release out_ready -> all OUT_DEPTH+2 results appear in order, none lost or duplicated;
  - 4096-beat random full-throttle run with random out_ready matches the scoreboard.
- Overflow, ACC_W=20, unsigned: three beats of 0xFF..FF -> out_data=512024 (1560600 mod 2^20), out_ovf=1. Next vector of zeros -> 0, out_ovf=0.
- Reset: 2 beats into a vector with one result queued, assert rst one cycle:
  - next cycle out_valid=0, in_ready=1;
  - following single-beat vector of 0x01 lanes -> 8, unaffected by old state.
